encoder_qep: RTL and testbench
==============================

# encoder_qep

Parametrised quadrature encoder interface, successor to the fixed 32-bit encoder block. It decodes filtered A/B/Z signals into a step counter and a single-revolution position. It also adds a programmable glitch filter, illegal-transition error counting, edge-period measurement for velocity estimation, direction inversion and a synchronous clear. Sits between the encoder input pins and the AXI register slave; the control loop snapshots it via `trigger`/`done`.

## Interface
- `CNT_W`, 32: width of counter, position and `pulses_per_rev`.
- `TMR_W`, 32: width of period timer.
- `FILT_W`, 4: width of `filt_len`.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `A`, `B`, `Z` in 1 each: raw encoder inputs, asynchronous to `clk`.
- `trigger` in 1: snapshot request, level-sampled each cycle.
- `clear` in 1: synchronous clear of `counter` and `err_count`.
- `pulses_per_rev` in CNT_W: steps per mechanical revolution.
- `filt_len` in FILT_W: extra stable cycles required by the glitch filter.
- `dir_invert` in 1: swaps increment/decrement.
- `z_enable` in 1: enables Z-index homing.
- `counter` out CNT_W: signed step count (two's complement), wraps.
- `position` out CNT_W: 0..pulses_per_rev-1, or all-ones while unhomed.
- `period` out TMR_W: clk cycles between the last two counted steps; all-ones = stalled/unknown.
- `err_count` out 16: illegal A/B transitions, saturating.
- `steps_synced`, `position_synced` out CNT_W; `period_synced` out TMR_W: snapshot registers.
- `done` out 1: snapshot complete.

## Operation
- **Synchronizer:** A, B and Z each pass through two flops.
- **Glitch filter (per input):** filtered reg `f` plus counter `c`.
  - If sync == `f`: `c`<=0.
  - Else if `c` >= `filt_len`: `f`<=sync, `c`<=0.
  - Else: `c`<=`c`+1.
  - A change must persist `filt_len`+1 consecutive cycles to propagate. Reset: `f`=0, `c`=0.
- **Decoder:** state reg holds the previous filtered {A,B}; reset 00.
  - Increment sequence: 00→10→11→01→00. The reverse sequence decrements.
  - `dir_invert`=1 swaps increment and decrement.
  - Both bits changing (00↔11, 01↔10) is illegal: no step, `err_count`+1 (saturating at 16'hFFFF), state takes the new value.
- **Counter:** ±1 per step, modulo 2^CNT_W. `clear` has priority over a same-cycle step.
- **Position:**
  - Filtered-Z rising edge with `z_enable`=1 sets position to 0 and sets the internal homed flag. This has priority over a same-cycle step.
  - Increment at pulses_per_rev-1 wraps to 0; decrement at 0 wraps to pulses_per_rev-1.
  - `pulses_per_rev`=0 gives wrap at 2^CNT_W.
  - Output is all-ones until homed. Internal register resets to all-ones; only a Z edge or `rst_n` affects homing. `clear` does not.
- **Period:**
  - Timer resets to all-ones, increments each cycle and saturates.
  - On a step cycle: `period`<=timer, timer<=1.
  - When the timer reaches all-ones: `period`<=all-ones.
  - Illegal transitions do not touch the timer.
- **Snapshot:**
  - Every cycle `trigger`=1 captures `counter`, `position` (masked value) and `period` into the synced registers.
  - `done`<=0 on the edge after `trigger`; `done`<=1 on the edge after the first cycle with `trigger`=0.

## Timing
- Reset values:
  - `counter`=0, `err_count`=0.
  - `position`, `position_synced`, `period`, `period_synced` = all-ones.
  - `steps_synced`=0, `done`=1.
- Input change sampled at edge 1 → `counter`/`position`/`period` update at edge 4+`filt_len`. Z uses the same latency.
- `trigger` high at edge t → synced regs valid and `done`=0 after t+1; `done`=1 after t+2 for a single-cycle trigger.
- `trigger` held high: recapture every cycle, `done` stays 0.
- Step and trigger in the same cycle: snapshot holds the pre-step value.
- `rst_n` asserted mid-operation: all registers go to reset values immediately; position is unhomed again.
- `filt_len` change mid-operation: takes effect on the next compare; no glitch on `f`.

## Test plan
- **Forward sequence:** `filt_len`=0, drive 00→10→11→01→00 ×10, one change per 20 cycles → `counter`=40, `period`=20, `err_count`=0.
- **Reverse and inversion:** reverse sequence ×1 → `counter`=-4 (all-ones-3). Repeat with `dir_invert`=1 → `counter` returns to 0.
- **Glitch filter:** `filt_len`=3, 3-cycle pulse on A → no step. 4-cycle pulse → exactly one inc then one dec, `counter` unchanged net.
- **Illegal transitions:** drive 00→11 and 01→10 → `err_count`=2, `counter` unchanged. 70000 illegal transitions → `err_count`=16'hFFFF.
- **Index and wrap:** `pulses_per_rev`=8.
  - `position`=all-ones before Z.
  - Z rise with step in the same cycle → `position`=0.
  - 9 increments → `position`=1; 2 decrements → `position`=7.
  - `clear` → `counter`=0, `position` unchanged.
- **Snapshot and stall:** `trigger` for 1 cycle → `done` low exactly 1 cycle, synced regs match live values. Hold `trigger` 5 cycles → `done` low 5 cycles. With no steps for 2^TMR_W cycles (TMR_W=8 bench) → `period`=8'hFF.

Source files
------------

// File: rtl/encoder_qep.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : encoder_qep
// Brief    : Quadrature encoder interface. Synchronises and glitch-filters
//            A/B/Z, decodes steps into a signed counter and a single-turn
//            position homed by Z, measures the step period and provides a
//            trigger/done snapshot port for the control loop.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module encoder_qep #(
    parameter int CNT_W  = 32,
    parameter int TMR_W  = 32,
    parameter int FILT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              A,
    input  logic              B,
    input  logic              Z,
    input  logic              trigger,
    input  logic              clear,
    input  logic [CNT_W-1:0]  pulses_per_rev,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              dir_invert,
    input  logic              z_enable,
    output logic [CNT_W-1:0]  counter,
    output logic [CNT_W-1:0]  position,
    output logic [TMR_W-1:0]  period,
    output logic [15:0]       err_count,
    output logic [CNT_W-1:0]  steps_synced,
    output logic [CNT_W-1:0]  position_synced,
    output logic [TMR_W-1:0]  period_synced,
    output logic              done
);

    localparam logic [CNT_W-1:0] C_CNT_ONES = '1;
    localparam logic [TMR_W-1:0] C_TMR_ONES = '1;
    localparam logic [15:0]      C_ERR_MAX  = 16'hFFFF;

    // ------------------------------------------------------------------
    // Two-flop synchronisers, bit order {A, B, Z}
    // ------------------------------------------------------------------
    logic [2:0] w_raw;
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [2:0] w_filt;

    assign w_raw = {A, B, Z};

    // Shift the raw pins through the two synchroniser stages.
    always_comb begin
        sync1_d = w_raw;
        sync2_d = sync1_q;
    end

    // Synchroniser registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // ------------------------------------------------------------------
    // Glitch filter per input: a new level must differ from the filtered
    // value for filt_len+1 consecutive cycles before it is accepted.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_filt
        logic              f_q, f_d;
        logic [FILT_W-1:0] c_q, c_d;

        // Count cycles of disagreement; accept the level once it has lasted.
        always_comb begin
            f_d = f_q;
            c_d = '0;
            if (sync2_q[gi] == f_q) begin
                c_d = '0;
            end else if (c_q >= filt_len) begin
                f_d = sync2_q[gi];
                c_d = '0;
            end else begin
                c_d = c_q + 1'b1;
            end
        end

        // Filter state registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                f_q <= 1'b0;
                c_q <= '0;
            end else begin
                f_q <= f_d;
                c_q <= c_d;
            end
        end

        assign w_filt[gi] = f_q;
    end

    // ------------------------------------------------------------------
    // Decoder: convert the Gray-coded {A,B} pair to a 2-bit phase so the
    // phase difference directly gives +1, -1 or an illegal double change.
    // ------------------------------------------------------------------
    function automatic logic [1:0] ab_phase(input logic [1:0] ab);
        ab_phase = {ab[0], ab[1] ^ ab[0]};
    endfunction

    logic [1:0] ab_q, ab_d;
    logic       z_prev_q, z_prev_d;
    logic [1:0] w_delta;
    logic       w_fwd, w_rev, w_illegal, w_step, w_inc, w_dec, w_z_rise;

    assign w_delta   = ab_phase(w_filt[2:1]) - ab_phase(ab_q);
    assign w_fwd     = (w_delta == 2'd1);
    assign w_rev     = (w_delta == 2'd3);
    assign w_illegal = (w_delta == 2'd2);
    assign w_step    = w_fwd | w_rev;
    assign w_inc     = dir_invert ? w_rev : w_fwd;
    assign w_dec     = dir_invert ? w_fwd : w_rev;
    assign w_z_rise  = w_filt[0] & ~z_prev_q;

    // ------------------------------------------------------------------
    // Counter, error counter and position
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [15:0]      err_q, err_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             homed_q, homed_d;

    // Step accounting: clear beats a step, Z homing beats a step.
    always_comb begin
        ab_d     = w_filt[2:1];
        z_prev_d = w_filt[0];

        counter_d = counter_q;
        if (clear) begin
            counter_d = '0;
        end else if (w_inc) begin
            counter_d = counter_q + 1'b1;
        end else if (w_dec) begin
            counter_d = counter_q - 1'b1;
        end

        err_d = err_q;
        if (clear) begin
            err_d = '0;
        end else if (w_illegal && (err_q != C_ERR_MAX)) begin
            err_d = err_q + 1'b1;
        end

        pos_d   = pos_q;
        homed_d = homed_q;
        if (w_z_rise && z_enable) begin
            pos_d   = '0;
            homed_d = 1'b1;
        end else if (homed_q && w_inc) begin
            // pulses_per_rev of zero means a natural 2^CNT_W wrap
            if ((pulses_per_rev != '0) && (pos_q >= pulses_per_rev - 1'b1)) begin
                pos_d = '0;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end else if (homed_q && w_dec) begin
            if (pos_q == '0) begin
                pos_d = pulses_per_rev - 1'b1;
            end else begin
                pos_d = pos_q - 1'b1;
            end
        end
    end

    // Decoder, counter and position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ab_q      <= 2'b00;
            z_prev_q  <= 1'b0;
            counter_q <= '0;
            err_q     <= '0;
            pos_q     <= C_CNT_ONES;
            homed_q   <= 1'b0;
        end else begin
            ab_q      <= ab_d;
            z_prev_q  <= z_prev_d;
            counter_q <= counter_d;
            err_q     <= err_d;
            pos_q     <= pos_d;
            homed_q   <= homed_d;
        end
    end

    // ------------------------------------------------------------------
    // Period measurement: saturating timer restarted by every counted step
    // ------------------------------------------------------------------
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [TMR_W-1:0] period_q, period_d;

    // Latch the elapsed time on a step; flag a stall once the timer saturates.
    always_comb begin
        timer_d  = timer_q;
        period_d = period_q;
        if (w_step) begin
            period_d = timer_q;
            timer_d  = {{(TMR_W-1){1'b0}}, 1'b1};
        end else if (timer_q == C_TMR_ONES) begin
            period_d = C_TMR_ONES;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Timer and period registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q  <= C_TMR_ONES;
            period_q <= C_TMR_ONES;
        end else begin
            timer_q  <= timer_d;
            period_q <= period_d;
        end
    end

    // ------------------------------------------------------------------
    // Snapshot port: capture pre-step values while trigger is high
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_pos_out;
    logic [CNT_W-1:0] ssteps_q, ssteps_d;
    logic [CNT_W-1:0] spos_q, spos_d;
    logic [TMR_W-1:0] sper_q, sper_d;
    logic             done_q, done_d;

    assign w_pos_out = homed_q ? pos_q : C_CNT_ONES;

    // Recapture every trigger cycle; done follows the inverse of trigger.
    always_comb begin
        ssteps_d = ssteps_q;
        spos_d   = spos_q;
        sper_d   = sper_q;
        done_d   = ~trigger;
        if (trigger) begin
            ssteps_d = counter_q;
            spos_d   = w_pos_out;
            sper_d   = period_q;
        end
    end

    // Snapshot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssteps_q <= '0;
            spos_q   <= C_CNT_ONES;
            sper_q   <= C_TMR_ONES;
            done_q   <= 1'b1;
        end else begin
            ssteps_q <= ssteps_d;
            spos_q   <= spos_d;
            sper_q   <= sper_d;
            done_q   <= done_d;
        end
    end

    assign counter         = counter_q;
    assign position        = w_pos_out;
    assign period          = period_q;
    assign err_count       = err_q;
    assign steps_synced    = ssteps_q;
    assign position_synced = spos_q;
    assign period_synced   = sper_q;
    assign done            = done_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder_qep.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_encoder_qep
// Brief    : Self-checking bench for encoder_qep with a behavioural model,
//            directed scenarios and a randomised phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encoder_qep;

    localparam int CNT_W  = 32;
    localparam int TMR_W  = 8;
    localparam int FILT_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              A = 1'b0, B = 1'b0, Z = 1'b0;
    logic              trigger = 1'b0, clear = 1'b0;
    logic              dir_invert = 1'b0, z_enable = 1'b0;
    logic [CNT_W-1:0]  ppr = '0;
    logic [FILT_W-1:0] filt_len = '0;

    logic [CNT_W-1:0]  counter, position, steps_synced, position_synced;
    logic [TMR_W-1:0]  period, period_synced;
    logic [15:0]       err_count;
    logic              done;

    encoder_qep #(.CNT_W(CNT_W), .TMR_W(TMR_W), .FILT_W(FILT_W)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Z(Z),
        .trigger(trigger), .clear(clear), .pulses_per_rev(ppr),
        .filt_len(filt_len), .dir_invert(dir_invert), .z_enable(z_enable),
        .counter(counter), .position(position), .period(period),
        .err_count(err_count), .steps_synced(steps_synced),
        .position_synced(position_synced), .period_synced(period_synced),
        .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [2:0]  m_s1, m_s2, m_f;
    int          m_run [3];
    logic [1:0]  m_ab;
    logic        m_zp;
    logic [31:0] m_cnt, m_pos, m_scnt, m_spos, m_pos_out;
    bit          m_homed;
    logic [15:0] m_err;
    int          m_timer;
    logic [7:0]  m_period, m_sper;
    logic        m_done;
    bit          m_valid = 0;
    int          m_d, m_sgn;
    bit          m_step;

    function automatic int ph(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_f = 0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
            m_ab = 0; m_zp = 0; m_cnt = 0; m_pos = '1; m_homed = 0;
            m_err = 0; m_timer = 255; m_period = 8'hFF;
            m_scnt = 0; m_spos = '1; m_sper = 8'hFF; m_done = 1;
            m_valid = 1;
        end else begin
            m_d       = (ph(m_f[2:1]) - ph(m_ab) + 4) % 4;
            m_step    = (m_d == 1) || (m_d == 3);
            m_sgn     = (m_d == 1) ? 1 : -1;
            if (dir_invert) m_sgn = -m_sgn;
            m_pos_out = m_homed ? m_pos : 32'hFFFF_FFFF;
            if (trigger) begin
                m_scnt = m_cnt; m_spos = m_pos_out; m_sper = m_period;
            end
            m_done = !trigger;
            if (clear) m_cnt = 0;
            else if (m_step) m_cnt = m_cnt + 32'(m_sgn);
            if (clear) m_err = 0;
            else if (m_d == 2 && m_err != 16'hFFFF) m_err = m_err + 16'd1;
            if (m_f[0] && !m_zp && z_enable) begin
                m_pos = 0; m_homed = 1;
            end else if (m_homed && m_step) begin
                if (ppr == 0) m_pos = m_pos + 32'(m_sgn);
                else m_pos = 32'((longint'(m_pos) + longint'(ppr) + m_sgn) % longint'(ppr));
            end
            if (m_step) begin
                m_period = 8'(m_timer); m_timer = 1;
            end else if (m_timer == 255) begin
                m_period = 8'hFF;
            end else begin
                m_timer++;
            end
            m_ab = m_f[2:1];
            m_zp = m_f[0];
            for (int i = 0; i < 3; i++) begin
                if (m_s2[i] == m_f[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] > int'(filt_len)) begin
                        m_f[i] = m_s2[i]; m_run[i] = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = {A, B, Z};
        end
    end

    // Compare every output against the model each cycle out of reset.
    always @(negedge clk) begin
        if (rst_n && m_valid) begin
            chk("counter", counter, m_cnt);
            chk("position", position, m_homed ? m_pos : 32'hFFFF_FFFF);
            chk("period", period, m_period);
            chk("err_count", err_count, m_err);
            chk("steps_synced", steps_synced, m_scnt);
            chk("position_synced", position_synced, m_spos);
            chk("period_synced", period_synced, m_sper);
            chk("done", done, m_done);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ab(input logic a, input logic b, input int hold);
        A = a; B = b;
        tick(hold);
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(1); clear = 1'b0;
    endtask

    task automatic snap(input int n, output int lows);
        trigger = 1'b1;
        lows = 0;
        for (int k = 0; k < n + 4; k++) begin
            @(posedge clk); #1;
            if (k == n - 1) trigger = 1'b0;
            if (!done) lows++;
        end
    endtask

    int lows;

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_counter", counter, 0);
        chk("rst_position", position, 32'hFFFF_FFFF);
        chk("rst_period", period, 8'hFF);
        chk("rst_err", err_count, 0);
        chk("rst_steps_synced", steps_synced, 0);
        chk("rst_position_synced", position_synced, 32'hFFFF_FFFF);
        chk("rst_period_synced", period_synced, 8'hFF);
        chk("rst_done", done, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(3);

        // Forward sequence, 40 steps 20 cycles apart
        repeat (10) begin
            set_ab(1, 0, 20); set_ab(1, 1, 20); set_ab(0, 1, 20); set_ab(0, 0, 20);
        end
        chk("fwd_counter", counter, 40);
        chk("fwd_period", period, 20);
        chk("fwd_err", err_count, 0);

        // Reverse, then reverse again with inversion
        pulse_clear();
        set_ab(0, 1, 20); set_ab(1, 1, 20); set_ab(1, 0, 20); set_ab(0, 0, 20);
        chk("rev_counter", counter, 32'hFFFF_FFFC);
        dir_invert = 1'b1;
        set_ab(0, 1, 20); set_ab(1, 1, 20); set_ab(1, 0, 20); set_ab(0, 0, 20);
        chk("inv_counter", counter, 0);
        dir_invert = 1'b0;

        // Glitch filter
        filt_len = 4'd3;
        A = 1'b1; tick(3); A = 1'b0; tick(12);
        chk("glitch3_counter", counter, 0);
        A = 1'b1; tick(4); A = 1'b0; tick(3);
        chk("glitch4_inc", counter, 1);
        tick(10);
        chk("glitch4_net", counter, 0);

        // Illegal transitions
        filt_len = 4'd0;
        pulse_clear();
        set_ab(1, 1, 10); set_ab(0, 1, 10); set_ab(1, 0, 10); set_ab(0, 0, 10);
        chk("illegal_err", err_count, 2);
        chk("illegal_counter", counter, 0);
        for (int i = 0; i < 70000; i++) begin
            A = (i % 2 == 0); B = (i % 2 == 0);
            tick(1);
        end
        tick(5);
        chk("err_saturate", err_count, 16'hFFFF);

        // Index homing and wrap
        ppr = 8; z_enable = 1'b1;
        tick(2);
        chk("unhomed_position", position, 32'hFFFF_FFFF);
        A = 1'b1; B = 1'b0; Z = 1'b1;
        tick(6);
        chk("home_position", position, 0);
        Z = 1'b0;
        set_ab(1, 1, 4); set_ab(0, 1, 4); set_ab(0, 0, 4); set_ab(1, 0, 4);
        set_ab(1, 1, 4); set_ab(0, 1, 4); set_ab(0, 0, 4); set_ab(1, 0, 4);
        set_ab(1, 1, 6);
        chk("wrap_up_position", position, 1);
        set_ab(1, 0, 4); set_ab(0, 0, 6);
        chk("wrap_down_position", position, 7);
        pulse_clear();
        tick(3);
        chk("clear_counter", counter, 0);
        chk("clear_position", position, 7);

        // Snapshot
        snap(1, lows);
        chk("done_low_1", lows, 1);
        chk("snap_steps", steps_synced, 0);
        chk("snap_position", position_synced, 7);
        snap(5, lows);
        chk("done_low_5", lows, 5);

        // Stall detection
        tick(300);
        chk("stall_period", period, 8'hFF);

        // Asynchronous reset mid-operation
        rst_n = 1'b0;
        #1;
        chk("async_position", position, 32'hFFFF_FFFF);
        chk("async_position_synced", position_synced, 32'hFFFF_FFFF);
        chk("async_done", done, 1);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Randomised operation: ppr = 8, then ppr = 0
        for (int i = 0; i < 4000; i++) begin
            if (i == 3000) ppr = 0;
            if ($urandom_range(3) == 0) begin
                A = 1'($urandom); B = 1'($urandom);
            end
            if ($urandom_range(15) == 0) Z = ~Z;
            trigger    = ($urandom_range(3) == 0);
            clear      = ($urandom_range(63) == 0);
            z_enable   = ($urandom_range(7) != 0);
            if ($urandom_range(99) == 0) dir_invert = ~dir_invert;
            if ($urandom_range(199) == 0) filt_len = 4'($urandom_range(3));
            tick(1);
        end
        trigger = 1'b0; clear = 1'b0;
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
